// File: rtl/power_domain_sequencer.sv
// Ordered power-down/up sequencer for NPU power domains: one shared FSM walks a
// single round-robin-granted domain through clock, isolation, retention and switch steps.
module power_domain_sequencer #(
  parameter int NUM_POWER_DOMAINS = 4,
  parameter int ISO_CYCLES        = 4,
  parameter int RET_CYCLES        = 8,
  parameter int ACK_TIMEOUT       = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_POWER_DOMAINS-1:0] power_gate_enable,
  input  logic [NUM_POWER_DOMAINS-1:0] clock_gate_enable,
  input  logic [NUM_POWER_DOMAINS-1:0] pwr_sw_ack,
  output logic [NUM_POWER_DOMAINS-1:0] pwr_sw_en,
  output logic [NUM_POWER_DOMAINS-1:0] iso_en,
  output logic [NUM_POWER_DOMAINS-1:0] ret_save,
  output logic [NUM_POWER_DOMAINS-1:0] ret_restore,
  output logic [NUM_POWER_DOMAINS-1:0] clk_en,
  output logic [NUM_POWER_DOMAINS-1:0] domain_ready,
  output logic [NUM_POWER_DOMAINS-1:0] domain_fault,
  output logic                         seq_busy,
  output logic                         seq_error
);

  localparam int N  = NUM_POWER_DOMAINS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [7:0] ISO_LAST = 8'(ISO_CYCLES - 1);
  localparam logic [7:0] RET_LAST = 8'(RET_CYCLES - 1);
  localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLK_OFF,
    S_ISO_ON,
    S_SAVE,
    S_SW_OFF,
    S_WAIT_OFF,
    S_SW_ON,
    S_WAIT_ON,
    S_RESTORE,
    S_ISO_OFF,
    S_DONE,
    S_FAULT
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          busy_q, busy_d;
  logic [N-1:0]  on_q, on_d;
  logic [N-1:0]  sw_q, sw_d;
  logic [N-1:0]  iso_q, iso_d;
  logic [N-1:0]  save_q, save_d;
  logic [N-1:0]  rest_q, rest_d;
  logic [N-1:0]  ready_q, ready_d;
  logic [N-1:0]  fault_q, fault_d;
  logic [N-1:0]  clk_q, clk_d;

  logic [N-1:0]  pending;
  logic          found;
  logic [IW-1:0] pick;

  // Round-robin pick: first pending domain at or after the pointer.
  always_comb begin
    pending = (power_gate_enable ^ on_q) & ~fault_q;
    found   = 1'b0;
    pick    = ptr_q;
    for (int k = 0; k < N; k++) begin
      if (!found && pending[(int'(ptr_q) + k) % N]) begin
        found = 1'b1;
        pick  = IW'((int'(ptr_q) + k) % N);
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    on_d    = on_q;
    sw_d    = sw_q;
    iso_d   = iso_q;
    ready_d = ready_q;
    fault_d = fault_q;
    save_d  = '0;
    rest_d  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = pick;
          ptr_d   = (int'(pick) == N - 1) ? '0 : pick + 1'b1;
          busy_d  = 1'b1;
          if (power_gate_enable[pick]) begin
            state_d    = S_SW_ON;
            sw_d[pick] = 1'b1;
          end else begin
            state_d       = S_CLK_OFF;
            ready_d[pick] = 1'b0;
          end
        end
      end
      S_CLK_OFF: if (cnt_q == 8'd1) begin
        state_d        = S_ISO_ON;
        iso_d[grant_q] = 1'b1;
      end
      S_ISO_ON: if (cnt_q == ISO_LAST) begin
        state_d         = S_SAVE;
        save_d[grant_q] = 1'b1;
      end
      S_SAVE: if (cnt_q == RET_LAST) begin
        state_d       = S_SW_OFF;
        sw_d[grant_q] = 1'b0;
      end
      S_SW_OFF: state_d = S_WAIT_OFF;
      S_WAIT_OFF: begin
        if (!pwr_sw_ack[grant_q]) begin
          state_d       = S_DONE;
          on_d[grant_q] = 1'b0;
        end else if (cnt_q == ACK_LAST) begin
          state_d          = S_FAULT;
          fault_d[grant_q] = 1'b1;
        end
      end
      S_SW_ON: state_d = S_WAIT_ON;
      S_WAIT_ON: begin
        if (pwr_sw_ack[grant_q]) begin
          state_d         = S_RESTORE;
          rest_d[grant_q] = 1'b1;
        end else if (cnt_q == ACK_LAST) begin
          state_d          = S_FAULT;
          fault_d[grant_q] = 1'b1;
        end
      end
      S_RESTORE: if (cnt_q == RET_LAST) begin
        state_d        = S_ISO_OFF;
        iso_d[grant_q] = 1'b0;
      end
      S_ISO_OFF: if (cnt_q == ISO_LAST) begin
        state_d          = S_DONE;
        on_d[grant_q]    = 1'b1;
        ready_d[grant_q] = 1'b1;
      end
      S_DONE, S_FAULT: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;

    // Clock drops with ready in the same cycle but only returns a cycle after ready.
    clk_d = clock_gate_enable & ready_q & ready_d;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      on_q    <= '1;
      sw_q    <= '1;
      iso_q   <= '0;
      save_q  <= '0;
      rest_q  <= '0;
      ready_q <= '1;
      fault_q <= '0;
      clk_q   <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      on_q    <= on_d;
      sw_q    <= sw_d;
      iso_q   <= iso_d;
      save_q  <= save_d;
      rest_q  <= rest_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
      clk_q   <= clk_d;
    end
  end

  assign pwr_sw_en    = sw_q;
  assign iso_en       = iso_q;
  assign ret_save     = save_q;
  assign ret_restore  = rest_q;
  assign clk_en       = clk_q;
  assign domain_ready = ready_q;
  assign domain_fault = fault_q;
  assign seq_busy     = busy_q;
  assign seq_error    = |fault_q;

endmodule

// File: tb/tb_power_domain_sequencer.sv
// Self-checking bench: a timeline model of each granted sequence is compared against
// the DUT every cycle, and directed scenarios pin event cycles with literal values.
module tb_power_domain_sequencer;

  localparam int N   = 4;
  localparam int ISO = 4;
  localparam int RET = 8;
  localparam int TMO = 255;

  localparam int F_SW = 0, F_ISO = 1, F_SAVE = 2, F_REST = 3, F_CLK = 4;
  localparam int F_RDY = 5, F_FLT = 6, F_BUSY = 7, F_ERR = 8;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] power_gate_enable = '1;
  logic [N-1:0] clock_gate_enable = '1;
  logic [N-1:0] pwr_sw_ack = '1;
  logic [N-1:0] pwr_sw_en, iso_en, ret_save, ret_restore, clk_en, domain_ready, domain_fault;
  logic         seq_busy, seq_error;

  int checks = 0;
  int errors = 0;

  power_domain_sequencer #(
    .NUM_POWER_DOMAINS(N), .ISO_CYCLES(ISO), .RET_CYCLES(RET), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .power_gate_enable(power_gate_enable), .clock_gate_enable(clock_gate_enable),
    .pwr_sw_ack(pwr_sw_ack), .pwr_sw_en(pwr_sw_en), .iso_en(iso_en),
    .ret_save(ret_save), .ret_restore(ret_restore), .clk_en(clk_en),
    .domain_ready(domain_ready), .domain_fault(domain_fault),
    .seq_busy(seq_busy), .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Switch environment: ack follows pwr_sw_en after delay cycles unless stuck.
  int           delay [N] = '{default: 1};
  bit           stuck [N] = '{default: 0};
  int           age   [N] = '{default: 0};
  logic [N-1:0] last_sw = '1;

  // Timeline model: outputs derived from the cycle offset t since grant.
  logic [N-1:0] m_sw, m_iso, m_save, m_rest, m_ready, m_clk, m_fault, m_on;
  bit m_busy, m_up, m_tmo;
  int m_g, m_ptr, m_t, m_wend, m_last;

  task automatic model_reset();
    m_sw = '1; m_iso = '0; m_save = '0; m_rest = '0; m_ready = '1; m_clk = '1;
    m_fault = '0; m_on = '1; m_busy = 0; m_up = 0; m_tmo = 0;
    m_g = 0; m_ptr = 0; m_t = 0; m_wend = 0; m_last = -1;
  endtask

  task automatic apply_events();
    if (!m_up) begin
      if (m_t == 1)               m_ready[m_g] = 1'b0;
      if (m_t == 3)               m_iso[m_g]   = 1'b1;
      if (m_t == 3 + ISO)         m_save[m_g]  = 1'b1;
      if (m_t == 3 + ISO + RET)   m_sw[m_g]    = 1'b0;
    end else if (m_t == 1) begin
      m_sw[m_g] = 1'b1;
    end
    if (m_wend != 0 && m_last < 0) begin
      if (m_tmo) begin
        if (m_t == m_wend) begin m_fault[m_g] = 1'b1; m_last = m_t; end
      end else if (!m_up) begin
        if (m_t == m_wend) begin m_on[m_g] = 1'b0; m_last = m_t; end
      end else begin
        if (m_t == m_wend)             m_rest[m_g] = 1'b1;
        if (m_t == m_wend + RET)       m_iso[m_g]  = 1'b0;
        if (m_t == m_wend + RET + ISO) begin
          m_on[m_g] = 1'b1; m_ready[m_g] = 1'b1; m_last = m_t;
        end
      end
    end
  endtask

  task automatic model_step();
    logic [N-1:0] prev_ready;
    bit found;
    int idx, w0;
    prev_ready = m_ready;
    m_save = '0;
    m_rest = '0;
    if (m_busy && m_t == m_last) begin
      m_busy = 0;
    end else if (m_busy) begin
      w0 = m_up ? 2 : 4 + ISO + RET;
      if (m_wend == 0 && m_t >= w0) begin
        if (pwr_sw_ack[m_g] === m_up) m_wend = m_t + 1;
        else if (m_t - w0 + 1 == TMO) begin m_wend = m_t + 1; m_tmo = 1; end
      end
      m_t++;
      apply_events();
    end else begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && power_gate_enable[idx] !== m_on[idx] && !m_fault[idx]) begin
          found = 1;
          m_g   = idx;
        end
      end
      if (found) begin
        m_busy = 1; m_up = power_gate_enable[m_g]; m_ptr = (m_g + 1) % N;
        m_t = 1; m_wend = 0; m_last = -1; m_tmo = 0;
        apply_events();
      end
    end
    m_clk = clock_gate_enable & prev_ready & m_ready;
  endtask

  // Per-cycle compare, then advance the switch environment and the model.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!reset) model_reset();
      check_vec("cycle_compare",
        {2'b0, m_sw, m_iso, m_save, m_rest, m_clk, m_ready, m_fault, m_busy, |m_fault},
        {2'b0, pwr_sw_en, iso_en, ret_save, ret_restore, clk_en, domain_ready,
         domain_fault, seq_busy, seq_error});
      for (int i = 0; i < N; i++) begin
        if (!reset) begin
          age[i] = 0; last_sw[i] = 1'b1; pwr_sw_ack[i] = 1'b1;
        end else begin
          if (pwr_sw_en[i] !== last_sw[i]) begin last_sw[i] = pwr_sw_en[i]; age[i] = 0; end
          else age[i]++;
          if (!stuck[i] && age[i] >= delay[i]) pwr_sw_ack[i] = pwr_sw_en[i];
        end
      end
      if (reset) model_step();
    end
  end

  // Trace of DUT outputs indexed by cycle offset from a grant cycle (t = 0).
  logic [N-1:0] tr [0:399][0:8];

  task automatic capture(input int n);
    for (int t = 0; t <= n; t++) begin
      @(negedge clk);
      tr[t][F_SW]   = pwr_sw_en;     tr[t][F_ISO] = iso_en;
      tr[t][F_SAVE] = ret_save;      tr[t][F_REST] = ret_restore;
      tr[t][F_CLK]  = clk_en;        tr[t][F_RDY] = domain_ready;
      tr[t][F_FLT]  = domain_fault;  tr[t][F_BUSY] = N'(seq_busy);
      tr[t][F_ERR]  = N'(seq_error);
    end
  endtask

  function automatic int first_t(input int f, input int b, input logic v, input int from, input int upto);
    for (int t = from; t <= upto; t++) if (tr[t][f][b] === v) return t;
    return -1;
  endfunction

  function automatic int count_val(input int f, input int b, input logic v, input int from, input int upto);
    int c = 0;
    for (int t = from; t <= upto; t++) if (tr[t][f][b] === v) c++;
    return c;
  endfunction

  task automatic set_req(input logic [N-1:0] v);
    @(posedge clk); #1 power_gate_enable = v;
  endtask

  initial begin
    int busy_cnt;
    #1 reset = 1'b0;

    // Reset values, then a quiet idle period with everything requested on.
    @(negedge clk);
    check("rst_pwr_sw_en", pwr_sw_en, 15);
    check("rst_clk_en", clk_en, 15);
    check("rst_domain_ready", domain_ready, 15);
    check("rst_iso_en", iso_en, 0);
    check("rst_seq_busy", seq_busy, 0);
    check("rst_domain_fault", domain_fault, 0);
    @(posedge clk); #1 reset = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (seq_busy !== 1'b0) busy_cnt++;
    end
    check("idle_busy_cycles", busy_cnt, 0);
    check("idle_pwr_sw_en", pwr_sw_en, 15);

    // Domain 2 down, ack drops one cycle after the switch opens.
    set_req(4'b1011);
    capture(20);
    check("dn_clk_off_t", first_t(F_CLK, 2, 1'b0, 0, 20), 1);
    check("dn_ready_off_t", first_t(F_RDY, 2, 1'b0, 0, 20), 1);
    check("dn_iso_on_t", first_t(F_ISO, 2, 1'b1, 0, 20), 3);
    check("dn_save_t", first_t(F_SAVE, 2, 1'b1, 0, 20), 7);
    check("dn_save_pulses", count_val(F_SAVE, 2, 1'b1, 0, 20), 1);
    check("dn_sw_off_t", first_t(F_SW, 2, 1'b0, 0, 20), 15);
    check("dn_busy_end_t", first_t(F_BUSY, 0, 1'b0, 1, 20), 18);
    check("dn_sw_final", tr[20][F_SW], 4'b1011);

    // Domain 2 back up, ack rises three cycles after the switch closes.
    delay[2] = 3;
    set_req(4'b1111);
    capture(22);
    check("up_sw_on_t", first_t(F_SW, 2, 1'b1, 0, 22), 1);
    check("up_restore_t", first_t(F_REST, 2, 1'b1, 0, 22), 5);
    check("up_restore_pulses", count_val(F_REST, 2, 1'b1, 0, 22), 1);
    check("up_iso_off_t", first_t(F_ISO, 2, 1'b0, 0, 22), 13);
    check("up_ready_t", first_t(F_RDY, 2, 1'b1, 0, 22), 17);
    check("up_clk_t", first_t(F_CLK, 2, 1'b1, 0, 22), 18);
    check("up_busy_end_t", first_t(F_BUSY, 0, 1'b0, 1, 22), 18);

    // Clock gating on a ready domain has one cycle of latency.
    @(posedge clk); #1 clock_gate_enable = 4'b1011;
    @(negedge clk); check("cg_hold", clk_en[2], 1);
    @(negedge clk); check("cg_off", clk_en[2], 0);
    @(posedge clk); #1 clock_gate_enable = 4'b1111;
    @(negedge clk); @(negedge clk); check("cg_on", clk_en[2], 1);

    // Domain 3 down, reset hits during its retention save step.
    set_req(4'b0111);
    capture(9);
    check("rs_pre_save", tr[7][F_SAVE], 4'b1000);
    check("rs_pre_iso", tr[9][F_ISO], 4'b1000);
    @(posedge clk); #1 reset = 1'b0;
    #1;
    check("rs_pwr_sw_en", pwr_sw_en, 15);
    check("rs_iso_en", iso_en, 0);
    check("rs_clk_en", clk_en, 15);
    check("rs_seq_busy", seq_busy, 0);
    power_gate_enable = 4'b0110;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Domains 0 and 3 pending together with the pointer back at 0.
    capture(40);
    check("ser_d0_clk_off_t", first_t(F_CLK, 0, 1'b0, 0, 40), 1);
    check("ser_d3_clk_off_t", first_t(F_CLK, 3, 1'b0, 0, 40), 19);
    check("ser_busy_gap", count_val(F_BUSY, 0, 1'b0, 1, 35), 1);
    check("ser_busy_end_t", first_t(F_BUSY, 0, 1'b0, 19, 40), 36);
    check("ser_sw_final", tr[40][F_SW], 4'b0110);

    // Domain 1 down with its ack stuck high: switch timeout.
    stuck[1] = 1'b1;
    set_req(4'b0100);
    capture(275);
    check("flt_t", first_t(F_FLT, 1, 1'b1, 0, 275), 271);
    check("flt_busy_end_t", first_t(F_BUSY, 0, 1'b0, 1, 275), 272);
    check("flt_domain_fault", tr[275][F_FLT], 4'b0010);
    check("flt_seq_error", tr[275][F_ERR], 1);
    check("flt_sw_held", tr[275][F_SW], 4'b0100);
    check("flt_iso_held", tr[275][F_ISO], 4'b1011);
    check("flt_ready", tr[275][F_RDY], 4'b0100);

    // Domain 0 back up; the faulted domain is never granted again.
    set_req(4'b0101);
    capture(60);
    check("post_d0_ready_t", first_t(F_RDY, 0, 1'b1, 0, 60), 15);
    check("post_no_regrant", count_val(F_BUSY, 0, 1'b1, 17, 60), 0);
    check("post_fault", tr[60][F_FLT], 4'b0010);
    check("post_sw_final", tr[60][F_SW], 4'b0101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
